// File: rtl/agc_envelope_detector.sv
// Gain stage plus windowed amplitude detector feeding the AGC loop controller.
// Define AGC_DET_PEAK_EN to report the window peak magnitude instead of the window mean.
module agc_envelope_detector #(
   parameter int WIDTH   = 19,
   parameter int GFRAC   = 16,
   parameter int LOG_WIN = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             io_in_valid,
   input  logic [WIDTH-1:0] io_in,
   input  logic [WIDTH-1:0] io_G,
   input  logic             io_clear,
   output logic             io_out_valid,
   output logic [WIDTH-1:0] io_out,
   output logic [WIDTH-1:0] io_Vout,
   output logic             io_Vout_valid
);

   localparam int PW  = 2 * WIDTH;
   localparam int WIN = 2 ** LOG_WIN;
`ifdef AGC_DET_PEAK_EN
   localparam int ACC_W = WIDTH;
`else
   localparam int ACC_W = WIDTH + LOG_WIN;
`endif
   localparam logic signed [PW-1:0] SAT_HI    = (PW'(1) <<< (WIDTH - 1)) - PW'(1);
   localparam logic signed [PW-1:0] SAT_LO    = -SAT_HI;
   localparam logic [LOG_WIN-1:0]   LAST_FILL = LOG_WIN'(WIN - 2);

   typedef enum logic {FILL, DUMP} win_state_t;

   // Window FSM state; FILL covers counts 0..WIN-2, DUMP is the last sample of a window.
   win_state_t state;

   logic signed [PW-1:0] in_ext;
   logic signed [PW-1:0] g_ext;
   logic signed [PW-1:0] prod_q;
   logic                 prod_valid;
   logic signed [PW-1:0] shifted;
   logic [WIDTH-1:0]     sat_val;
   logic [WIDTH-1:0]     mag;
   logic [ACC_W-1:0]     acc;
   logic [LOG_WIN-1:0]   cnt;
   logic [ACC_W-1:0]     base_acc;
   logic [LOG_WIN-1:0]   base_cnt;
   win_state_t           base_state;
   logic [ACC_W-1:0]     acc_upd;
   logic [WIDTH-1:0]     vout_new;

   // The gain is unsigned, so it is zero-extended before the signed multiply.
   assign in_ext = {{WIDTH{io_in[WIDTH-1]}}, io_in};
   assign g_ext  = {{WIDTH{1'b0}}, io_G};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prod_valid <= 1'b0;
         prod_q     <= '0;
      end else begin
         prod_valid <= io_in_valid;
         if (io_in_valid) begin
            prod_q <= in_ext * g_ext;
         end
      end
   end

   // Symmetric saturation keeps the most negative code off the output.
   always_comb begin
      shifted = prod_q >>> GFRAC;
      sat_val = shifted[WIDTH-1:0];
      if (shifted > SAT_HI) begin
         sat_val = SAT_HI[WIDTH-1:0];
      end else if (shifted < SAT_LO) begin
         sat_val = SAT_LO[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         io_out_valid <= 1'b0;
         io_out       <= '0;
      end else begin
         io_out_valid <= prod_valid;
         if (prod_valid) begin
            io_out <= sat_val;
         end
      end
   end

   // Clear is folded in first so a coincident sample starts the new window.
   always_comb begin
      mag        = io_out[WIDTH-1] ? (~io_out + WIDTH'(1)) : io_out;
      base_acc   = io_clear ? '0 : acc;
      base_cnt   = io_clear ? '0 : cnt;
      base_state = io_clear ? FILL : state;
`ifdef AGC_DET_PEAK_EN
      acc_upd    = (mag > base_acc) ? mag : base_acc;
      vout_new   = acc_upd;
`else
      acc_upd    = base_acc + {{LOG_WIN{1'b0}}, mag};
      vout_new   = acc_upd[ACC_W-1:LOG_WIN];
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc           <= '0;
         cnt           <= '0;
         state         <= FILL;
         io_Vout       <= '0;
         io_Vout_valid <= 1'b0;
      end else begin
         io_Vout_valid <= 1'b0;
         acc           <= base_acc;
         cnt           <= base_cnt;
         state         <= base_state;
         if (io_out_valid) begin
            if (base_state == DUMP) begin
               io_Vout       <= vout_new;
               io_Vout_valid <= 1'b1;
               acc           <= '0;
               cnt           <= '0;
               state         <= FILL;
            end else begin
               acc   <= acc_upd;
               cnt   <= base_cnt + LOG_WIN'(1);
               state <= (base_cnt == LAST_FILL) ? DUMP : FILL;
            end
         end
      end
   end

endmodule

// File: tb/tb_agc_envelope_detector.sv
// Directed bench for agc_envelope_detector: queued expectations checked by a negedge monitor.
module tb_agc_envelope_detector;

   localparam int W = 19;

   logic         clk = 1'b0;
   logic         reset;
   logic         io_in_valid;
   logic [W-1:0] io_in;
   logic [W-1:0] io_G;
   logic         io_clear;
   logic         io_out_valid;
   logic [W-1:0] io_out;
   logic [W-1:0] io_Vout;
   logic         io_Vout_valid;

   agc_envelope_detector #(.WIDTH(W), .GFRAC(16), .LOG_WIN(2)) dut (
      .clk           (clk),
      .reset         (reset),
      .io_in_valid   (io_in_valid),
      .io_in         (io_in),
      .io_G          (io_G),
      .io_clear      (io_clear),
      .io_out_valid  (io_out_valid),
      .io_out        (io_out),
      .io_Vout       (io_Vout),
      .io_Vout_valid (io_Vout_valid)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard state
   logic [W-1:0] exp_q[$];
   int           exp_cyc_q[$];
   logic [W-1:0] vexp_q[$];
   int           vexp_cyc_q[$];
   logic [W-1:0] vout_model = '0;
   int           last_in_cyc = 0;
   int           checks = 0;
   int           errors = 0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h) at cycle %0d",
                  name, $signed(act), act, $signed(req), req, cyc);
      end
   endtask

   task automatic check_int(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Driver tasks
   task automatic drive(input int v, input int g, input logic clr, input int e);
      @(posedge clk);
      #1;
      io_in_valid = 1'b1;
      io_in       = W'(v);
      io_G        = W'(g);
      io_clear    = clr;
      exp_q.push_back(W'(e));
      exp_cyc_q.push_back(cyc + 2);
      last_in_cyc = cyc;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         io_in_valid = 1'b0;
         io_in       = W'($urandom_range(0, 2 ** W - 1));
         io_G        = W'($urandom_range(0, 2 ** W - 1));
         io_clear    = 1'b0;
      end
   endtask

   task automatic expect_vout(input int mean_v, input int peak_v);
`ifdef AGC_DET_PEAK_EN
      vexp_q.push_back(W'(peak_v));
`else
      vexp_q.push_back(W'(mean_v));
`endif
      vexp_cyc_q.push_back(last_in_cyc + 3);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_io_out"}, io_out, '0);
      check({tag, "_io_out_valid"}, W'(io_out_valid), '0);
      check({tag, "_io_Vout"}, io_Vout, '0);
      check({tag, "_io_Vout_valid"}, W'(io_Vout_valid), '0);
   endtask

   // Monitor: pops expectations whenever the DUT presents an output
   always @(negedge clk) begin
      logic [W-1:0] e;
      int           ec;
      if (!reset) begin
         vout_model = '0;
      end else begin
         if (io_out_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL io_out_unexpected: got %0d, expected no output at cycle %0d",
                        $signed(io_out), cyc);
            end else begin
               e  = exp_q.pop_front();
               ec = exp_cyc_q.pop_front();
               check("io_out", io_out, e);
               check_int("io_out_cycle", cyc, ec);
            end
         end
         if (io_Vout_valid) begin
            if (vexp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL io_Vout_unexpected: got %0d, expected no pulse at cycle %0d",
                        io_Vout, cyc);
            end else begin
               e  = vexp_q.pop_front();
               ec = vexp_cyc_q.pop_front();
               check("io_Vout", io_Vout, e);
               check_int("io_Vout_cycle", cyc, ec);
               vout_model = e;
            end
         end else begin
            check("io_Vout_hold", io_Vout, vout_model);
         end
      end
   end

   initial begin
      reset       = 1'b0;
      io_in_valid = 1'b0;
      io_in       = '0;
      io_G        = '0;
      io_clear    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(posedge clk);
      #3;
      reset = 1'b1;

      // Unity gain
      drive(100, 65536, 1'b0, 100);
      drive(-200, 65536, 1'b0, -200);
      drive(300, 65536, 1'b0, 300);
      drive(-400, 65536, 1'b0, -400);
      expect_vout(250, 400);
      idle(1);

      // Saturation and floor rounding; magnitudes 262143+262143+1+2 form one window
      drive(200000, 131072, 1'b0, 262143);
      drive(-200000, 131072, 1'b0, -262143);
      drive(3, 32768, 1'b0, 1);
      drive(-3, 32768, 1'b0, -2);
      expect_vout(131072, 262143);
      idle(1);

      // Bubbles between valid samples
      drive(100, 65536, 1'b0, 100);
      idle(2);
      drive(-200, 65536, 1'b0, -200);
      idle(1);
      drive(300, 65536, 1'b0, 300);
      idle(3);
      drive(-400, 65536, 1'b0, -400);
      expect_vout(250, 400);
      idle(1);

      // Clear coincides with the third sample reaching the accumulator
      drive(1000, 65536, 1'b0, 1000);
      drive(2000, 65536, 1'b0, 2000);
      drive(40, 65536, 1'b0, 40);
      drive(-80, 65536, 1'b0, -80);
      drive(120, 65536, 1'b1, 120);
      drive(-160, 65536, 1'b0, -160);
      expect_vout(100, 160);
      idle(1);

      // Reset in the middle of a window
      drive(10, 65536, 1'b0, 10);
      drive(20, 65536, 1'b0, 20);
      idle(4);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      @(posedge clk);
      #3;
      reset = 1'b1;
      drive(10, 65536, 1'b0, 10);
      drive(-20, 65536, 1'b0, -20);
      drive(30, 65536, 1'b0, 30);
      drive(-40, 65536, 1'b0, -40);
      expect_vout(25, 40);
      idle(1);

      for (int i = 0; i < 20 && (exp_q.size() != 0 || vexp_q.size() != 0); i++) begin
         @(posedge clk);
      end
      checks++;
      if (exp_q.size() != 0 || vexp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d samples and %0d amplitudes still pending, expected 0 and 0",
                  exp_q.size(), vexp_q.size());
      end
      idle(3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/agc_envelope_detector.md
# agc_envelope_detector

Gain-application and amplitude-measurement stage that sits directly upstream of the AGC loop controller. It multiplies each incoming signed sample by the controller's current gain word `io_G`, saturates the result, and forwards the gained sample. It also averages the gained-sample magnitude over a fixed window and presents the average as `io_Vout`, which the AGC compares against `io_Vref` to close the loop.

## Interface
Parameters:
- `WIDTH`, 19: sample, gain and amplitude width.
- `GFRAC`, 16: fractional bits of `io_G`; unsigned Q(WIDTH-GFRAC).GFRAC, so 65536 = 1.0.
- `LOG_WIN`, 2: window length is 2^LOG_WIN valid samples.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `io_in_valid`  in  1  `io_in` carries a sample this cycle.
- `io_in`  in  WIDTH  signed input sample.
- `io_G`  in  WIDTH  unsigned gain, captured with each valid sample.
- `io_clear`  in  1  synchronous window restart.
- `io_out_valid`  out  1  `io_out` valid.
- `io_out`  out  WIDTH  signed gained, saturated sample.
- `io_Vout`  out  WIDTH  unsigned windowed amplitude; feeds AGC `io_Vout`.
- `io_Vout_valid`  out  1  one-cycle pulse when `io_Vout` updates.

## Operation
- Stage 1: on a valid sample, register the full 2·WIDTH signed product `io_in * {0,io_G}` and a valid bit. `io_G` is ignored when `io_in_valid`=0.
- Stage 2: arithmetic right shift by GFRAC (floor rounding). Then saturate symmetrically to [-(2^(WIDTH-1)-1), 2^(WIDTH-1)-1] (±262143), so the most negative code is never produced. Register the result into `io_out`/`io_out_valid`.
- Stage 3: when `io_out_valid`=1, add |`io_out`| into a (WIDTH+LOG_WIN)-bit accumulator and increment a LOG_WIN-bit sample counter.
  - When the counter wraps from 2^LOG_WIN-1 to 0, load `io_Vout` with (acc + |io_out|) >> LOG_WIN (truncated) and pulse `io_Vout_valid`.
  - The accumulator then restarts at 0.
- `io_Vout` holds its value between updates.
- Counter FSM: FILL (count 0..2^LOG_WIN-2) and DUMP (last sample of the window). DUMP returns to FILL on the same edge.
- `io_clear`=1: zero the accumulator and counter.
  - If a stage-3 sample is present in the same cycle, it becomes sample 0 of the new window (clear wins over accumulate).
  - In-flight stage-1/2 samples are not flushed.
  - `io_Vout` is not modified.
- Mid-window change of `io_G`: affects only samples captured after the change. No window restart.
- Invalid cycles (bubbles) do not advance the counter. A window spans exactly 2^LOG_WIN valid samples regardless of gaps.

## Timing
- Reset (`reset`=0, asynchronous) clears all pipeline valids, the product, the accumulator and the counter. Output reset values: `io_out`=0, `io_out_valid`=0, `io_Vout`=0, `io_Vout_valid`=0.
- Reset asserted mid-window discards the partial window. The first window after release starts at sample 0.
- Sample latency: a valid sample in cycle n appears on `io_out` with `io_out_valid`=1 in cycle n+2.
- Full throughput: one sample per cycle, no backpressure.
- Amplitude latency: the last window sample input in cycle n gives updated `io_Vout` and `io_Vout_valid`=1 in cycle n+3.
- The accumulator cannot overflow: its width is WIDTH+LOG_WIN.

## Configuration
- `AGC_DET_PEAK_EN` defined: stage 3 tracks the maximum |`io_out`| over the window instead of the sum. `io_Vout` gets the window peak, with no shift. The accumulator is replaced by a WIDTH-bit max register. Clear, window and latency rules are unchanged.
- `AGC_DET_PEAK_EN` undefined: mean-magnitude behaviour as described in Operation.

## Test plan
- Unity gain: `io_G`=65536, LOG_WIN=2, inputs 100, -200, 300, -400 back-to-back -> `io_out` 100, -200, 300, -400 from cycle 2; `io_Vout`=250 with a single `io_Vout_valid` pulse 3 cycles after the last input.
- Saturation/rounding:
  - `io_G`=131072 with inputs 200000, -200000 -> `io_out` 262143, -262143.
  - `io_G`=32768 with inputs 3, -3 -> 1, -2.
- Bubbles: the same four samples with idle cycles between them -> `io_Vout`=250, exactly one pulse after the 4th valid sample.
- Clear: two samples in, assert `io_clear` coincident with the 3rd sample at stage 3, then 3 more samples -> the window holds samples 3..6 only, and `io_Vout` is unchanged until then.
- Reset mid-window: after 2 samples, pulse `reset` low -> all outputs 0 asynchronously; the next 4 samples form a complete window.
- With `AGC_DET_PEAK_EN`: inputs 100, -200, 300, -400 at unity gain -> `io_Vout`=400.
